// File: rtl/pipelined_cla_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshake. Stage 1 registers bit and group generate/propagate terms;
// stage 2 resolves the carries and registers sum and flags.
module pipelined_cla_addsub #(
  parameter int N     = 16,
  parameter int G     = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NG = N / G;

  // Stage 1 state: per-bit and per-group lookahead terms.
  logic [N-1:0]     p1_q, g1_q;
  logic [NG-1:0]    gp1_q, gg1_q;
  logic             c0_q;
  logic [TAG_W-1:0] tag1_q;
  logic             v1_q;

  // Stage 2 state: final result, driven straight to the outputs.
  logic [N-1:0]     sum_q;
  logic             cout_q, ovf_q, zero_q;
  logic [TAG_W-1:0] tag2_q;
  logic             v2_q;

  // Next-state values for both stages.
  logic [N-1:0]     p_d, g_d;
  logic [NG-1:0]    gp_d, gg_d;
  logic [N:0]       c_d;
  logic [N-1:0]     sum_d;

  logic s1_adv, s2_adv;

  // A stage may advance when it is empty or the stage after it is moving.
  assign s2_adv   = !v2_q || out_ready;
  assign s1_adv   = !v1_q || s2_adv;
  assign in_ready = s1_adv;

  // Bit generate/propagate on the conditionally inverted B, then group terms.
  always_comb begin : grp_terms
    logic [N-1:0] bx;
    logic         gp_t, gg_t;
    // NOTE: every combinational output gets a default first so no path
    // through the loops can leave a value unassigned and infer a latch.
    gp_d = '0;
    gg_d = '0;
    bx   = b ^ {N{sub}};
    p_d  = a ^ bx;
    g_d  = a & bx;
    for (int j = 0; j < NG; j++) begin
      gp_t = 1'b1;
      gg_t = 1'b0;
      for (int k = 0; k < G; k++) begin
        gg_t = g_d[j*G+k] | (p_d[j*G+k] & gg_t);
        gp_t = gp_t & p_d[j*G+k];
      end
      gp_d[j] = gp_t;
      gg_d[j] = gg_t;
    end
  end

  // Group carries from the group terms, then per-bit carries inside each group.
  always_comb begin : carry_resolve
    logic c_grp, c_bit;
    c_d   = '0;
    c_grp = c0_q;
    for (int j = 0; j < NG; j++) begin
      c_bit = c_grp;
      for (int k = 0; k < G; k++) begin
        c_d[j*G+k] = c_bit;
        c_bit      = g1_q[j*G+k] | (p1_q[j*G+k] & c_bit);
      end
      c_grp = gg1_q[j] | (gp1_q[j] & c_grp);
    end
    c_d[N] = c_grp;
    sum_d  = p1_q ^ c_d[N-1:0];
  end

  // Stage 1 register: captures operands-derived terms whenever it may advance.
  // NOTE: data registers are reset too, so outputs read as zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      p1_q   <= '0;
      g1_q   <= '0;
      gp1_q  <= '0;
      gg1_q  <= '0;
      c0_q   <= 1'b0;
      tag1_q <= '0;
      v1_q   <= 1'b0;
    end else if (s1_adv) begin
      p1_q   <= p_d;
      g1_q   <= g_d;
      gp1_q  <= gp_d;
      gg1_q  <= gg_d;
      c0_q   <= cin ^ sub;
      tag1_q <= in_tag;
      v1_q   <= in_valid;
    end
  end

  // Stage 2 register: holds the result steady while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      tag2_q <= '0;
      v2_q   <= 1'b0;
    end else if (s2_adv) begin
      sum_q  <= sum_d;
      cout_q <= c_d[N];
      ovf_q  <= c_d[N] ^ c_d[N-1];
      zero_q <= (sum_d == '0);
      tag2_q <= tag1_q;
      v2_q   <= v1_q;
    end
  end

  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign out_tag   = tag2_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench: directed vectors, backpressure and mid-stream reset
// on an 8-bit instance, plus random streaming on 8-bit and 32-bit instances
// against an arithmetic reference model.
module tb_pipelined_cla_addsub;

  typedef struct {
    longint     sum;
    bit         cout;
    bit         ovf;
    bit         zero;
    logic [3:0] tag;
  } exp_t;

  typedef struct {
    logic [7:0] a, b;
    bit         cin, sub;
    logic [3:0] tag;
    logic [7:0] sum;
    bit         cout, ovf, zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-bit instance signals
  logic       in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8;
  logic [7:0] a8, b8, sum8;
  logic       cout8, ovf8, zero8;
  logic [3:0] in_tag8, tag8;

  // 32-bit instance signals
  logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32;
  logic [31:0] a32, b32, sum32;
  logic        cout32, ovf32, zero32;
  logic [3:0]  in_tag32, tag32;

  pipelined_cla_addsub #(.N(8), .G(4), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
    .cout(cout8), .ovf(ovf8), .zero(zero8), .out_tag(tag8)
  );

  pipelined_cla_addsub #(.N(32), .G(8), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32), .in_tag(in_tag32),
    .out_valid(out_valid32), .out_ready(out_ready32), .sum(sum32),
    .cout(cout32), .ovf(ovf32), .zero(zero32), .out_tag(tag32)
  );

  int checks = 0;
  int errors = 0;
  exp_t q8[$];
  exp_t q32[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t ref_model(input int n, input longint ua, input longint ub,
                                     input bit ci, input bit sb, input logic [3:0] t);
    exp_t   e;
    longint m, r, sa, sbv, sr;
    m   = longint'(1) << n;
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    if (!sb) begin
      r      = ua + ub + longint'(ci);
      e.cout = (r >= m);
      sr     = sa + sbv + longint'(ci);
    end else begin
      r      = ua - ub - longint'(ci);
      e.cout = (r >= 0);
      sr     = sa - sbv - longint'(ci);
    end
    e.sum  = r & (m - 1);
    e.ovf  = (sr >= m / 2) || (sr < -(m / 2));
    e.zero = (e.sum == 0);
    e.tag  = t;
    return e;
  endfunction

  function automatic logic [63:0] pack_exp(input exp_t e);
    return {21'b0, e.sum[31:0], e.cout, e.ovf, e.zero, e.tag};
  endfunction

  function automatic logic [63:0] got8();
    return {21'b0, 24'b0, sum8, cout8, ovf8, zero8, tag8};
  endfunction

  function automatic logic [63:0] got32();
    return {21'b0, sum32, cout32, ovf32, zero32, tag32};
  endfunction

  // Drive the 8-bit instance at the falling edge, then settle before sampling.
  task automatic drive8(input bit v, input logic [7:0] a, input logic [7:0] b,
                        input bit ci, input bit sb, input logic [3:0] t, input bit ordy);
    @(negedge clk);
    in_valid8 = v; a8 = a; b8 = b; cin8 = ci; sub8 = sb; in_tag8 = t; out_ready8 = ordy;
    #2;
  endtask

  // Scoreboard bookkeeping for whatever handshakes complete this cycle.
  task automatic sb8();
    exp_t e;
    if (in_valid8 && in_ready8) q8.push_back(ref_model(8, a8, b8, cin8, sub8, in_tag8));
    if (out_valid8 && out_ready8) begin
      if (q8.size() == 0) check("sb8_unexpected", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        check("sb8_result", got8(), pack_exp(e));
      end
    end
  endtask

  task automatic sb32();
    exp_t e;
    if (in_valid32 && in_ready32) q32.push_back(ref_model(32, a32, b32, cin32, sub32, in_tag32));
    if (out_valid32 && out_ready32) begin
      if (q32.size() == 0) check("sb32_unexpected", 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        check("sb32_result", got32(), pack_exp(e));
      end
    end
  endtask

  vec_t vecs[10];

  initial begin
    int acc, emi;
    bit fell;
    logic [63:0] held;

    vecs[0] = '{8'hFF, 8'h01, 0, 0, 4'd3,  8'h00, 1, 0, 1};
    vecs[1] = '{8'h7F, 8'h01, 0, 0, 4'd1,  8'h80, 0, 1, 0};
    vecs[2] = '{8'h80, 8'h01, 0, 1, 4'd2,  8'h7F, 1, 1, 0};
    vecs[3] = '{8'h05, 8'h07, 0, 1, 4'd4,  8'hFE, 0, 0, 0};
    vecs[4] = '{8'h05, 8'h04, 1, 1, 4'd5,  8'h00, 1, 0, 1};
    vecs[5] = '{8'h12, 8'h34, 1, 0, 4'd6,  8'h47, 0, 0, 0};
    vecs[6] = '{8'h00, 8'h00, 0, 1, 4'd7,  8'h00, 1, 0, 1};
    vecs[7] = '{8'h80, 8'h80, 0, 0, 4'd8,  8'h00, 1, 1, 1};
    vecs[8] = '{8'h7F, 8'hFF, 0, 1, 4'd9,  8'h80, 0, 1, 0};
    vecs[9] = '{8'hFF, 8'hFF, 1, 0, 4'd10, 8'hFF, 1, 0, 0};

    rst_n = 1'b0;
    in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; in_tag8 = 0; out_ready8 = 1;
    in_valid32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; in_tag32 = 0; out_ready32 = 1;

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    check("rst_out_valid", out_valid8, 0);
    check("rst_outputs", got8(), 0);
    check("rst_in_ready", in_ready8, 1);
    check("rst_out_valid32", out_valid32, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with exact 2-cycle latency
    foreach (vecs[i]) begin
      drive8(1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].tag, 1);
      check("vec_accept", in_ready8, 1);
      drive8(0, 0, 0, 0, 0, 0, 1);
      check("vec_lat1_not_valid", out_valid8, 0);
      drive8(0, 0, 0, 0, 0, 0, 1);
      check("vec_lat2_valid", out_valid8, 1);
      check($sformatf("vec%0d_result", i), got8(),
            {21'b0, 24'b0, vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero, vecs[i].tag});
    end
    drive8(0, 0, 0, 0, 0, 0, 1);
    q8.delete();

    // Backpressure: stream tags 0..9, stall downstream during cycles 3-7
    acc = 0; emi = 0; fell = 0; held = '0;
    for (int c = 0; c < 60 && emi < 10; c++) begin
      drive8(acc < 10, 8'(acc * 7 + 3), 8'(acc * 13), acc[0], acc[1], 4'(acc),
             !(c >= 3 && c <= 7));
      if (!fell && !in_ready8) begin
        fell = 1;
        check("bp_occupancy", acc - emi, 2);
      end
      if (c >= 3 && c <= 7) begin
        check("bp_stall_in_ready", in_ready8, 0);
        check("bp_stall_valid", out_valid8, 1);
        if (c > 3) check("bp_hold", got8(), held);
        held = got8();
      end
      if (c >= 8) check("bp_one_per_cycle", out_valid8, 1);
      if (in_valid8 && in_ready8) acc++;
      if (out_valid8 && out_ready8) emi++;
      sb8();
    end
    check("bp_all_emitted", emi, 10);
    check("bp_queue_empty", q8.size(), 0);

    // Reset mid-operation with two transactions in flight
    drive8(1, 8'h11, 8'h22, 0, 0, 4'd1, 1);
    drive8(1, 8'h33, 8'h44, 0, 0, 4'd2, 0);
    drive8(0, 0, 0, 0, 0, 0, 0);
    check("mid_pre_valid", out_valid8, 1);
    check("mid_pre_in_ready", in_ready8, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid8, 0);
    check("mid_rst_outputs", got8(), 0);
    check("mid_rst_in_ready", in_ready8, 1);
    #1;
    rst_n = 1'b1;
    q8.delete();
    for (int k = 0; k < 4; k++) begin
      drive8(0, 0, 0, 0, 0, 0, 1);
      check("mid_no_stale", out_valid8, 0);
    end
    drive8(1, 8'h9C, 8'h64, 0, 1, 4'd6, 1);
    drive8(0, 0, 0, 0, 0, 0, 1);
    check("mid_post_lat1", out_valid8, 0);
    drive8(0, 0, 0, 0, 0, 0, 1);
    check("mid_post_valid", out_valid8, 1);
    check("mid_post_result", got8(), {21'b0, 24'b0, 8'h38, 1'b1, 1'b1, 1'b0, 4'd6});
    drive8(0, 0, 0, 0, 0, 0, 1);

    // Random streaming on both instances with random backpressure
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      in_valid8   = ($urandom_range(0, 3) != 0);
      a8          = 8'($urandom);
      b8          = 8'($urandom);
      cin8        = 1'($urandom);
      sub8        = 1'($urandom);
      in_tag8     = 4'($urandom);
      out_ready8  = ($urandom_range(0, 3) != 0);
      in_valid32  = ($urandom_range(0, 3) != 0);
      a32         = $urandom;
      b32         = $urandom;
      cin32       = 1'($urandom);
      sub32       = 1'($urandom);
      in_tag32    = 4'($urandom);
      out_ready32 = ($urandom_range(0, 3) != 0);
      #2;
      sb8();
      sb32();
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid8 = 0; out_ready8 = 1; in_valid32 = 0; out_ready32 = 1;
      #2;
      sb8();
      sb32();
    end
    check("rand8_drained", q8.size(), 0);
    check("rand32_drained", q32.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
